// File: rtl/mdu_riscv.sv
// rtl/mdu_riscv.sv - iterative RV32M multiply/divide unit, one bit per cycle
// Optional zero-operand fast path: define MDU_ZERO_BYPASS_EN
module mdu_riscv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_op;
    logic              r_sa;
    logic              r_sb;
    logic              r_fast;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_result;
    logic [2*XLEN-1:0] r_acc;
    logic [CW-1:0]     r_cnt;

    logic              w_accept;
    logic              w_sgn_a;
    logic              w_sgn_b;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_b_zero;
    logic              w_ovf;
    logic              w_zero_fast;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_rsh;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_acc_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign req_ready  = (r_state == IDLE) & rst_n;
    assign resp_valid = (r_state == DONE);
    assign w_accept   = req_valid & req_ready;

    // Signedness by funct3: MUL/MULH/DIV/REM both, MULHSU rs1 only
    assign w_sgn_a = req_op[2] ? ~req_op[0] : (req_op[1:0] != 2'b11);
    assign w_sgn_b = req_op[2] ? ~req_op[0] : ~req_op[1];
    assign w_neg_a = w_sgn_a & req_a[XLEN-1];
    assign w_neg_b = w_sgn_b & req_b[XLEN-1];
    assign w_mag_a = w_neg_a ? -req_a : req_a;
    assign w_mag_b = w_neg_b ? -req_b : req_b;

    assign w_b_zero = req_op[2] & (req_b == '0);
    assign w_ovf    = req_op[2] & ~req_op[0] & (&req_b)
                    & (req_a == {1'b1, {(XLEN-1){1'b0}}});

`ifdef MDU_ZERO_BYPASS_EN
    assign w_zero_fast = req_op[2] ? ((req_a == '0) & (req_b != '0))
                                   : ((req_a == '0) | (req_b == '0));
`else
    assign w_zero_fast = 1'b0;
`endif

    assign w_special = w_b_zero | w_ovf | w_zero_fast;

    always_comb begin
        w_special_res = '0;
        if (w_b_zero)
            w_special_res = req_op[1] ? req_a : {XLEN{1'b1}};
        else if (w_ovf)
            w_special_res = req_op[1] ? '0 : req_a;
    end

    // Multiply keeps the multiplier in the low half and shifts right;
    // divide keeps the dividend/quotient in the low half and shifts left.
    assign w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_rsh  = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff = w_rsh - {1'b0, r_b};

    always_comb begin
        w_acc_step = {w_sum, r_acc[XLEN-1:1]};
        if (r_op[2]) begin
            if (w_diff[XLEN])
                w_acc_step = {w_rsh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            else
                w_acc_step = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end
    end

    assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quot = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_final = w_rem;
        case (r_op)
            3'b000:                 w_final = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quot;
            default:                w_final = w_rem;
        endcase
    end

    assign resp_result = r_fast ? r_result : w_final;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_special ? DONE : CALC;
            CALC:    if (r_cnt == CW'(1)) w_next = DONE;
            DONE:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_fast   <= 1'b0;
            r_b      <= '0;
            r_result <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op     <= req_op;
                        r_sa     <= w_neg_a;
                        r_sb     <= w_neg_b;
                        r_fast   <= w_special;
                        r_result <= w_special_res;
                        r_b      <= w_mag_b;
                        r_acc    <= {{XLEN{1'b0}}, w_mag_a};
                        r_cnt    <= CW'(XLEN);
                    end
                end
                CALC: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_riscv.sv
// tb/tb_mdu_riscv.sv - scoreboard testbench for mdu_riscv
module tb_mdu_riscv;
    localparam int XLEN = 32;
`ifdef MDU_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_op = '0;
    logic [XLEN-1:0] req_a = '0;
    logic [XLEN-1:0] req_b = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [XLEN-1:0] resp_result;

    int checks = 0;
    int failures = 0;
    logic [XLEN-1:0] exp_q[$];

    mdu_riscv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result)
    );

    always #5 clk = ~clk;

    // Latency counts rising edges from the accept edge (inclusive) to resp_valid.
    task automatic do_op(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] expv, output logic [XLEN-1:0] res,
                         output int lat, output bit rdy_seen);
        exp_q.push_back(expv);
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        lat = 0; rdy_seen = 1'b0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            req_valid = 1'b0;
            req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
            if (resp_valid) break;
            if (req_ready) rdy_seen = 1'b1;
        end
        res = resp_result;
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++;
        if (resp_result !== '0) begin failures++; $display("FAIL reset_resp_result got=%h exp=0", resp_result); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_mul_latency();
        logic [XLEN-1:0] r, e; int lat; bit rs;
        do_op(3'b000, 32'd7, 32'd6, 32'd42, r, lat, rs);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL mul_result got=%h exp=%h", r, e); end
        checks++;
        if (lat != 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        checks++;
        if (rs) begin failures++; $display("FAIL mul_req_ready_busy got=1 exp=0"); end
        ack();
    endtask

    task automatic test_high_mul();
        logic [2:0]      ops[3] = '{3'b001, 3'b011, 3'b010};
        logic [XLEN-1:0] as[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [XLEN-1:0] bs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
        logic [XLEN-1:0] es[3]  = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [XLEN-1:0] r, e; int lat; bit rs;
        for (int i = 0; i < 3; i++) begin
            do_op(ops[i], as[i], bs[i], es[i], r, lat, rs);
            e = exp_q.pop_front();
            checks++;
            if (r !== e) begin failures++; $display("FAIL high_mul[%0d] got=%h exp=%h", i, r, e); end
            ack();
        end
    endtask

    task automatic test_div_rem();
        logic [2:0]      ops[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [XLEN-1:0] as[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [XLEN-1:0] bs[4]  = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [XLEN-1:0] es[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [XLEN-1:0] r, e; int lat; bit rs;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], es[i], r, lat, rs);
            e = exp_q.pop_front();
            checks++;
            if (r !== e || lat != 33) begin
                failures++; $display("FAIL div_rem[%0d] got=%h lat=%0d exp=%h lat=33", i, r, lat, e);
            end
            ack();
        end
    endtask

    task automatic test_special();
        logic [2:0]      ops[4] = '{3'b100, 3'b111, 3'b100, 3'b110};
        logic [XLEN-1:0] as[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [XLEN-1:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [XLEN-1:0] es[4]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [XLEN-1:0] r, e; int lat; bit rs;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], es[i], r, lat, rs);
            e = exp_q.pop_front();
            checks++;
            if (r !== e) begin failures++; $display("FAIL special[%0d] got=%h exp=%h", i, r, e); end
            checks++;
            if (lat != 1) begin failures++; $display("FAIL special_lat[%0d] got=%0d exp=1", i, lat); end
            ack();
        end
    endtask

    task automatic test_backpressure();
        logic [XLEN-1:0] r, e; int lat; bit rs; int bad;
        do_op(3'b101, 32'd100, 32'd7, 32'd14, r, lat, rs);
        e = exp_q.pop_front();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_result !== e || req_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL backpressure_hold bad_cycles=%0d exp=0 result=%h exp=%h", bad, resp_result, e); end
        @(negedge clk); resp_ready = 1'b1; #1;
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL handshake_cycle_ready got=%b exp=0", req_ready); end
        @(posedge clk); #1; resp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++; $display("FAIL after_handshake ready=%b valid=%b exp ready=1 valid=0", req_ready, resp_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [XLEN-1:0] r, e; int lat; bit rs; int seen;
        @(negedge clk);
        req_op = 3'b000; req_a = 32'h1234; req_b = 32'h5678; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1; rst_n = 1'b0; #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            failures++; $display("FAIL midreset_outputs valid=%b ready=%b exp 0 0", resp_valid, req_ready);
        end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL aborted_response cycles=%0d exp=0", seen); end
        do_op(3'b000, 32'd3, 32'd3, 32'd9, r, lat, rs);
        e = exp_q.pop_front();
        checks++;
        if (r !== e || lat != 33) begin failures++; $display("FAIL mul_after_reset got=%h lat=%0d exp=%h lat=33", r, lat, e); end
        ack();
    endtask

    task automatic test_zero_operand();
        logic [XLEN-1:0] r, e; int lat; bit rs;
        do_op(3'b000, 32'd0, 32'h12345, 32'd0, r, lat, rs);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL zero_mul got=%h exp=%h", r, e); end
        checks++;
        if (lat != ZLAT) begin failures++; $display("FAIL zero_mul_lat got=%0d exp=%0d", lat, ZLAT); end
        ack();
        do_op(3'b101, 32'd0, 32'd9, 32'd0, r, lat, rs);
        e = exp_q.pop_front();
        checks++;
        if (r !== e || lat != ZLAT) begin failures++; $display("FAIL zero_divu got=%h lat=%0d exp=%h lat=%0d", r, lat, e, ZLAT); end
        ack();
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] r, e; int lat; bit rs;
        for (int i = 0; i < 4; i++) begin
            logic [XLEN-1:0] a, b;
            a = $urandom; b = $urandom_range(1, 1000);
            do_op(3'b101, a, b, a / b, r, lat, rs);
            e = exp_q.pop_front();
            checks++;
            if (r !== e) begin failures++; $display("FAIL b2b_divu[%0d] got=%h exp=%h", i, r, e); end
            ack();
            do_op(3'b011, a, b, 32'(({32'd0, a} * {32'd0, b}) >> 32), r, lat, rs);
            e = exp_q.pop_front();
            checks++;
            if (r !== e) begin failures++; $display("FAIL b2b_mulhu[%0d] got=%h exp=%h", i, r, e); end
            ack();
        end
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_high_mul();
        test_div_rem();
        test_special();
        test_backpressure();
        test_reset_mid();
        test_zero_operand();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_riscv.md
Name: mdu_riscv

Overview:
- Iterative multiply/divide unit implementing the RV32M operations, parametrised in operand width.
- Sits beside the integer ALU in the execute stage.
- Takes requests over a valid/ready handshake, computes one bit per cycle, and returns the result over a second valid/ready handshake.
- The core stalls on req_ready/resp_valid.

Parameters:
- XLEN, 32: operand/result width (≥4). Iteration counter width is $clog2(XLEN)+1.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_op  input  3  operation, funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_a  input  XLEN  rs1 operand
- req_b  input  XLEN  rs2 operand
- resp_valid  output  1  result available
- resp_ready  input  1  consumer takes result
- resp_result  output  XLEN  result

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; resp_valid=0; resp_result=0; req_ready=0.
  - All internal registers (operands, accumulator, counter, sign flags) cleared.
  - Reset mid-operation aborts silently; no response is ever produced for the aborted request.
- req_ready = (state==IDLE) & rst_n. Accept = req_valid & req_ready on a rising edge.
- Capture at accept: op, operand magnitudes, sign flags.
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - Others: unsigned.
  - Later input changes are ignored.
- FSM states IDLE, CALC, DONE:
  - IDLE→DONE on accept when a special case applies (see below).
  - IDLE→CALC on any other accept; counter loaded with XLEN.
  - CALC: one iteration per cycle, counter decrements; →DONE when counter reaches 0 (after exactly XLEN iterations).
  - DONE: resp_valid=1, resp_result stable; →IDLE on resp_ready.
  - req_ready stays 0 throughout DONE, including the handshake cycle; the next accept is possible at the earliest one cycle after the response handshake.
- Multiply:
  - Radix-2 shift-add on magnitudes into a 2·XLEN accumulator.
  - At CALC exit, negate the full 2·XLEN product if the signs differ.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes.
  - Quotient negated if sign(a)≠sign(b) for signed ops.
  - Remainder takes the sign of a.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases (fast path, resp_valid on the first edge after accept):
  - b==0: quotient = all ones; remainder = a.
  - Signed overflow (DIV/REM, a=100…0, b=all ones): quotient = a; remainder = 0.
- Latency:
  - Normal: resp_valid rises XLEN+1 edges after the accept edge (33 for XLEN=32).
  - Special case: 1 edge.
- Backpressure: DONE holds indefinitely while resp_ready=0; resp_result must not change.
- resp_ready while resp_valid=0: ignored.
- Arithmetic: all arithmetic is modulo width; no flags; no exceptions.

Optional Feature:
- Macro: MDU_ZERO_BYPASS_EN.
- Defined:
  - Any multiply op with req_a==0 or req_b==0 takes the fast path: IDLE→DONE, result 0, latency 1.
  - DIV/DIVU/REM/REMU with req_a==0 and req_b≠0 also take the fast path, result 0.
- Undefined:
  - Zero operands take the normal XLEN+1 latency with identical results.
  - No extra comparator logic is instantiated.

Test Plan:
- Normal multiply latency: MUL a=7 b=6 → resp_result=42, resp_valid exactly 33 edges after accept, req_ready=0 throughout.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- Division and remainder:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
  - All respond 1 edge after accept.
- Backpressure and reset:
  - resp_ready=0 for 10 cycles → resp_valid and resp_result held, req_ready=0; handshake then gives req_ready=1 on the next cycle.
  - rst_n pulsed low at CALC iteration 10 → resp_valid=0 immediately; after release, MUL 3×3 → 9.
- Macro on/off: MUL 0×12345 → 0.
  - With MDU_ZERO_BYPASS_EN: latency 1.
  - Without: latency 33.
